// File: rtl/mem_arbiter_if.sv
// Purpose : bundles the fetch port, data port and shared-memory bus of mem_arbiter.
// Latency : none (wires only); timing is defined by the arbiter.
// Backpr. : requesters hold *_req until *_gnt; no credit or ready path to the memory.
// Ports   : i_* fetch request/response, d_* load/store request/response,
//           mem_* unified memory bus, busy arbiter status.
// Modports: slave = arbiter view, master = requesters + memory view.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic [31:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_funct3,
        output d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_write, mem_wdata, mem_funct3,
        input  mem_rdata,
        output busy
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_funct3,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_write, mem_wdata, mem_funct3,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose : shares one unified memory between instruction fetch (I) and load/store (D).
// Latency : gnt combinational in the request cycle; rvalid MEM_LATENCY cycles after gnt.
// Backpr. : one access in flight; requests seen while busy get no gnt and must be held.
// Ports   : clk, reset (async, active low), bus (mem_arbiter_if.slave).
// Config  : MEM_LATENCY (1-4). Define MEM_ARBITER_ROUND_ROBIN_EN for alternating
//           grants on simultaneous requests; default is fixed D-over-I priority.
module mem_arbiter #(
    parameter int MEM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

    state_t      state_q;
    owner_t      owner_q;
    logic [1:0]  cnt_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    owner_t      last_q;
`endif

    logic        idle;
    logic        wait_st;
    logic        pick_d;
    logic        grant;
    logic        done;
    logic [31:0] sel_addr;
    logic [2:0]  sel_funct3;

    // Reset gates the combinational grant path so gnt/mem_* drop the moment
    // reset goes low, even while a requester is still holding its request.
    assign idle    = reset && (state_q == S_IDLE);
    assign wait_st = reset && (state_q == S_WAIT);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // D wins when it is alone, or when both request and I was granted last.
    assign pick_d = bus.d_req && (!bus.i_req || (last_q == OWN_I));
`else
    assign pick_d = bus.d_req;
`endif

    assign bus.d_gnt = idle && pick_d;
    assign bus.i_gnt = idle && bus.i_req && !pick_d;
    assign grant     = bus.d_gnt || bus.i_gnt;

    always_comb begin
        sel_addr   = 32'h0;
        sel_funct3 = 3'b000;
        if (bus.d_gnt) begin
            sel_addr   = bus.d_addr;
            sel_funct3 = bus.d_funct3;
        end else if (bus.i_gnt) begin
            sel_addr   = bus.i_addr;
            sel_funct3 = 3'b010;   // fetches are always full words
        end
    end

    assign bus.mem_addr   = wait_st ? addr_q   : sel_addr;
    assign bus.mem_funct3 = wait_st ? funct3_q : sel_funct3;
    // Store data is only needed in the grant cycle; the bus is quiet afterwards.
    assign bus.mem_wdata  = bus.d_gnt ? bus.d_wdata : 32'h0;
    assign bus.mem_write  = bus.d_gnt && bus.d_we;

    // The counter reaches zero in the cycle the memory presents its data.
    assign done = wait_st && (cnt_q == 2'd0);

    assign bus.i_rvalid = done && (owner_q == OWN_I);
    assign bus.d_rvalid = done && (owner_q == OWN_D);
    assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : 32'h0;
    assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : 32'h0;

    assign bus.busy = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_I;
            cnt_q    <= 2'd0;
            addr_q   <= 32'h0;
            funct3_q <= 3'b000;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_q   <= OWN_I;
`endif
        end else if (state_q == S_IDLE) begin
            if (grant) begin
                state_q  <= S_WAIT;
                owner_q  <= pick_d ? OWN_D : OWN_I;
                cnt_q    <= 2'(MEM_LATENCY - 1);
                addr_q   <= sel_addr;
                funct3_q <= sel_funct3;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                last_q   <= pick_d ? OWN_D : OWN_I;
`endif
            end
        end else begin
            if (cnt_q == 2'd0) begin
                state_q <= S_IDLE;
            end else begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 1, memory read latency in cycles from address to valid mem_rdata; legal range 1-4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  instruction-fetch request; i_addr  input  32  fetch byte address.
REQ-005 i_gnt  output  1  fetch request accepted this cycle; i_rvalid  output  1  fetch data valid; i_rdata  output  32  fetch data.
REQ-006 d_req  input  1  load/store request; d_we  input  1  1=store, 0=load; d_addr  input  32  byte address; d_wdata  input  32  store data; d_funct3  input  3  access size/sign.
REQ-007 d_gnt  output  1  data request accepted this cycle; d_rvalid  output  1  load data valid or store complete; d_rdata  output  32  load data.
REQ-008 mem_addr  output  32; mem_write  output  1; mem_wdata  output  32; mem_funct3  output  3; mem_rdata  input  32  to/from the shared unified memory.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-010 The block SHALL share the single unified memory between fetch (I) and data (D) ports, one access in flight at a time.
REQ-011 FSM states SHALL be IDLE and WAIT; reset state IDLE.
REQ-012 In IDLE with at least one request, the winner's gnt SHALL assert combinationally that cycle, its address/funct3/wdata SHALL drive mem_* combinationally, and the FSM SHALL enter WAIT.
REQ-013 Fetch grants SHALL drive mem_funct3=3'b010 and mem_write=0.
REQ-014 mem_write SHALL be high only in the grant cycle of a D store (d_we=1), never in WAIT.
REQ-015 On grant the block SHALL register owner, address and funct3; in WAIT mem_addr/mem_funct3 SHALL hold the registered values and mem_wdata SHALL be 0.
REQ-016 A latency counter SHALL load MEM_LATENCY-1 on grant and decrement each WAIT cycle; when it is 0 in WAIT, the owner's rvalid SHALL pulse for exactly one cycle, its rdata SHALL equal mem_rdata that cycle, and the FSM SHALL return to IDLE.
REQ-017 Grant cycle T gives rvalid in cycle T+MEM_LATENCY; next grant earliest T+MEM_LATENCY+1.
REQ-018 i_rdata/d_rdata SHALL be 0 whenever the corresponding rvalid is low.
REQ-019 Stores SHALL produce d_rvalid as a completion pulse with the same timing as loads.
REQ-020 Requests SHALL be sampled only in IDLE; requests in WAIT are ignored (no gnt) and must be held by the requester.
REQ-021 Both gnt outputs SHALL never be high in the same cycle; at most one rvalid per cycle.
REQ-022 Default arbitration: D has fixed priority over I when both request.
REQ-023 No request in IDLE: gnt, rvalid, mem_write all 0, mem_addr 0, FSM stays IDLE.

Reset
REQ-024 Reset low SHALL immediately force IDLE, counter 0, owner I, all gnt/rvalid/mem_write/busy 0, mem_addr/mem_wdata/rdata 0.
REQ-025 Reset mid-access SHALL abort it with no rvalid pulse after release; first request after release is granted normally.

Configuration
REQ-026 Macro MEM_ARBITER_ROUND_ROBIN_EN: when defined, simultaneous requests SHALL grant the port not granted last (last-grant pointer, reset value I, so D wins first); a single requester always wins.
REQ-027 Without MEM_ARBITER_ROUND_ROBIN_EN, fixed D priority (REQ-022) SHALL apply and no pointer register SHALL exist.

Verification (MEM_LATENCY=1 unless noted)
REQ-028 i_req=1, i_addr=0x0000_0010, mem_rdata=0x0050_0093 -> i_gnt in cycle 0, mem_addr=0x10, i_rvalid=1 and i_rdata=0x0050_0093 in cycle 1, busy 1 in cycle 1 only.
REQ-029 d_req=1, d_we=1, d_addr=0x0000_0100, d_wdata=0xDEAD_BEEF, d_funct3=3'b010 -> mem_write=1 only in cycle 0, d_rvalid pulse cycle 1, i_rvalid stays 0.
REQ-030 i_req and d_req held high together (fixed priority) -> grant sequence D,D,D every 2 cycles, i_gnt never asserts; with MEM_ARBITER_ROUND_ROBIN_EN -> D,I,D,I.
REQ-031 MEM_LATENCY=3, D load at cycle 0 -> d_rvalid only in cycle 3; i_req raised cycle 1 ignored until i_gnt in cycle 4.
REQ-032 Reset driven low in cycle 1 of a MEM_LATENCY=3 fetch -> outputs zero immediately, no i_rvalid after release, next i_req granted in its first IDLE cycle.
